// File: rtl/audio_out_serializer.sv
// I2S transmit serializer: pops one left/right pair per LRCLK frame from show-ahead FIFOs
// and shifts each channel out MSB-first with the standard one-BCLK delay.
module audio_out_serializer #(
    parameter int unsigned AUDIO_DATA_WIDTH = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic                        bit_clk_falling_edge,
    input  logic                        left_right_clk_rising_edge,
    input  logic                        left_right_clk_falling_edge,
    input  logic                        left_fifo_empty,
    input  logic [AUDIO_DATA_WIDTH-1:0] left_fifo_data,
    output logic                        left_fifo_read,
    input  logic                        right_fifo_empty,
    input  logic [AUDIO_DATA_WIDTH-1:0] right_fifo_data,
    output logic                        right_fifo_read,
    input  logic                        clear_underflow,
    output logic                        underflow,
    output logic                        underflow_sticky,
    output logic                        serial_audio_out_data
);

    localparam int unsigned W = AUDIO_DATA_WIDTH;

    logic [W-1:0] shift_reg_q, shift_reg_d;
    logic [W-1:0] right_hold_q, right_hold_d;
    logic         sdo_q, sdo_d;
    logic         pop_q, pop_d;
    logic         uf_q, uf_d;
    logic         sticky_q, sticky_d;

    always_comb begin
        shift_reg_d  = shift_reg_q;
        right_hold_d = right_hold_q;
        sdo_d        = sdo_q;
        pop_d        = 1'b0;
        uf_d         = 1'b0;
        sticky_d     = sticky_q;

        // LRCLK fall wins over a (illegal) coincident rise.
        if (left_right_clk_falling_edge) begin
            shift_reg_d  = '0;
            right_hold_d = '0;
            if (enable) begin
                if (!left_fifo_empty && !right_fifo_empty) begin
                    shift_reg_d  = left_fifo_data;
                    right_hold_d = right_fifo_data;
                    pop_d        = 1'b1;
                end else begin
                    uf_d = 1'b1;
                end
            end
        end else if (left_right_clk_rising_edge) begin
            shift_reg_d = right_hold_q;
        end else if (bit_clk_falling_edge) begin
            shift_reg_d = {shift_reg_q[W-2:0], 1'b0};
        end

        // Output takes the pre-load MSB, giving the one-bit I2S delay.
        if (bit_clk_falling_edge) begin
            sdo_d = shift_reg_q[W-1];
        end

        // Set also holds through the pulse cycle so a clear there cannot drop a fresh event.
        if (uf_d || uf_q) begin
            sticky_d = 1'b1;
        end else if (clear_underflow) begin
            sticky_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shift_reg_q  <= '0;
            right_hold_q <= '0;
            sdo_q        <= 1'b0;
            pop_q        <= 1'b0;
            uf_q         <= 1'b0;
            sticky_q     <= 1'b0;
        end else begin
            shift_reg_q  <= shift_reg_d;
            right_hold_q <= right_hold_d;
            sdo_q        <= sdo_d;
            pop_q        <= pop_d;
            uf_q         <= uf_d;
            sticky_q     <= sticky_d;
        end
    end

    assign left_fifo_read        = pop_q;
    assign right_fifo_read       = pop_q;
    assign underflow             = uf_q;
    assign underflow_sticky      = sticky_q;
    assign serial_audio_out_data = sdo_q;

endmodule

// File: tb/tb_audio_out_serializer.sv
// Directed bench for audio_out_serializer: table of whole LR frames plus reset,
// sticky-clear and coincident-clear sequences.
module tb_audio_out_serializer;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        bit_clk_falling_edge;
    logic        left_right_clk_rising_edge;
    logic        left_right_clk_falling_edge;
    logic        left_fifo_empty;
    logic [15:0] left_fifo_data;
    logic        left_fifo_read;
    logic        right_fifo_empty;
    logic [15:0] right_fifo_data;
    logic        right_fifo_read;
    logic        clear_underflow;
    logic        underflow;
    logic        underflow_sticky;
    logic        serial_audio_out_data;

    int checks = 0;
    int errors = 0;

    audio_out_serializer #(.AUDIO_DATA_WIDTH(16)) dut (
        .clk                         (clk),
        .reset                       (reset),
        .enable                      (enable),
        .bit_clk_falling_edge        (bit_clk_falling_edge),
        .left_right_clk_rising_edge  (left_right_clk_rising_edge),
        .left_right_clk_falling_edge (left_right_clk_falling_edge),
        .left_fifo_empty             (left_fifo_empty),
        .left_fifo_data              (left_fifo_data),
        .left_fifo_read              (left_fifo_read),
        .right_fifo_empty            (right_fifo_empty),
        .right_fifo_data             (right_fifo_data),
        .right_fifo_read             (right_fifo_read),
        .clear_underflow             (clear_underflow),
        .underflow                   (underflow),
        .underflow_sticky            (underflow_sticky),
        .serial_audio_out_data       (serial_audio_out_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        en_start;
        logic        en_mid;
        logic        le;
        logic        re;
        logic [15:0] ld;
        logic [15:0] rd;
        logic [15:0] exp_l;
        logic [15:0] exp_r;
        int          exp_pops;
        int          exp_uf;
        logic        exp_sticky;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // One LR frame = 64 BCLK falls, one every 2 clocks; LRCLK fall at cycle 0, rise at 64.
    task automatic run_frame(input logic en_start, input logic en_mid, input logic le,
                             input logic re, input logic [15:0] ld, input logic [15:0] rd,
                             input logic clr0, output logic [15:0] got_l,
                             output logic [15:0] got_r, output int stray, output int pops,
                             output int pop_at, output int ufs, output int uf_at,
                             output int lr_diff);
        int k;
        got_l = '0; got_r = '0; stray = 0; pops = 0; pop_at = -1;
        ufs = 0; uf_at = -1; lr_diff = 0;
        left_fifo_empty  = le;
        right_fifo_empty = re;
        left_fifo_data   = ld;
        right_fifo_data  = rd;
        enable           = en_start;
        for (int c = 0; c < 128; c++) begin
            bit_clk_falling_edge        = (c % 2 == 0);
            left_right_clk_falling_edge = (c == 0);
            left_right_clk_rising_edge  = (c == 64);
            clear_underflow             = clr0 && (c == 0);
            if (en_mid && c == 40) enable = 1'b1;
            @(posedge clk);
            #1;
            if (left_fifo_read) begin
                pops++;
                if (pop_at < 0) pop_at = c;
            end
            if (left_fifo_read != right_fifo_read) lr_diff++;
            if (underflow) begin
                ufs++;
                if (uf_at < 0) uf_at = c;
            end
            if (c % 2 == 0) begin
                k = c / 2 + 1;
                if (k >= 2 && k <= 17) got_l[17-k] = serial_audio_out_data;
                else if (k >= 34 && k <= 49) got_r[49-k] = serial_audio_out_data;
                else if (k >= 2 && serial_audio_out_data) stray++;
            end
        end
        bit_clk_falling_edge        = 1'b0;
        left_right_clk_falling_edge = 1'b0;
        left_right_clk_rising_edge  = 1'b0;
        clear_underflow             = 1'b0;
    endtask

    task automatic frame_checks(input string tag, input vec_t v, input logic clr0);
        logic [15:0] gl, gr;
        int stray, pops, pop_at, ufs, uf_at, lr_diff;
        run_frame(v.en_start, v.en_mid, v.le, v.re, v.ld, v.rd, clr0,
                  gl, gr, stray, pops, pop_at, ufs, uf_at, lr_diff);
        check({tag, " left_bits"},  int'(gl), int'(v.exp_l));
        check({tag, " right_bits"}, int'(gr), int'(v.exp_r));
        check({tag, " zero_fill"},  stray, 0);
        check({tag, " pop_count"},  pops, v.exp_pops);
        check({tag, " pop_cycle"},  pop_at, (v.exp_pops != 0) ? 0 : -1);
        check({tag, " pop_pair"},   lr_diff, 0);
        check({tag, " uf_count"},   ufs, v.exp_uf);
        check({tag, " uf_cycle"},   uf_at, (v.exp_uf != 0) ? 0 : -1);
        check({tag, " sticky"},     int'(underflow_sticky), int'(v.exp_sticky));
    endtask

    initial begin
        int bad, pops, ones;
        vec_t v;

        //         en  mid le  re  ld        rd        exp_l     exp_r     pop uf stk
        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'hA5C3, 16'h0F01, 16'hA5C3, 16'h0F01, 1, 0, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 16'h1234, 16'h5678, 16'h0000, 16'h0000, 0, 1, 1'b1};
        vecs[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 0, 0, 1'b1};
        vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 0, 0, 1'b1};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 0, 0, 1'b1};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 0, 0, 1'b1};
        vecs[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h8001, 16'h7FFE, 16'h8001, 16'h7FFE, 1, 0, 1'b1};
        vecs[7] = '{1'b1, 1'b0, 1'b1, 1'b0, 16'hBEEF, 16'hCAFE, 16'h0000, 16'h0000, 0, 1, 1'b1};

        reset = 1'b1; enable = 1'b0;
        bit_clk_falling_edge = 1'b0;
        left_right_clk_rising_edge = 1'b0;
        left_right_clk_falling_edge = 1'b0;
        left_fifo_empty = 1'b1; right_fifo_empty = 1'b1;
        left_fifo_data = '0; right_fifo_data = '0;
        clear_underflow = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", int'({left_fifo_read, right_fifo_read, underflow,
                                     underflow_sticky, serial_audio_out_data}), 0);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Prime frame so the shifter holds a known state before the table.
        run_frame(1'b0, 1'b0, 1'b1, 1'b1, 16'h0, 16'h0, 1'b0, v.ld, v.rd, bad, pops, bad,
                  bad, bad, bad);

        for (int i = 0; i < 8; i++) begin
            frame_checks($sformatf("vec%0d", i), vecs[i], 1'b0);
        end

        // Sticky clears on request with no new underflow.
        clear_underflow = 1'b1;
        @(posedge clk);
        #1;
        clear_underflow = 1'b0;
        check("sticky_clear", int'(underflow_sticky), 0);
        check("no_uf_on_clear", int'(underflow), 0);

        // Clear coincident with a fresh underflow: set wins.
        v = '{1'b1, 1'b0, 1'b0, 1'b1, 16'h1111, 16'h2222, 16'h0000, 16'h0000, 0, 1, 1'b1};
        frame_checks("coincident_clear", v, 1'b1);

        // Reset mid-shift of a live frame.
        enable = 1'b1;
        left_fifo_empty = 1'b0; right_fifo_empty = 1'b0;
        left_fifo_data = 16'hA5C3; right_fifo_data = 16'h0F01;
        bad = 0;
        for (int c = 0; c < 30; c++) begin
            bit_clk_falling_edge        = (c % 2 == 0);
            left_right_clk_falling_edge = (c == 0);
            reset                       = (c >= 20 && c < 23);
            @(posedge clk);
            #1;
            if (c >= 20 && c < 23 &&
                {left_fifo_read, right_fifo_read, underflow, underflow_sticky,
                 serial_audio_out_data} != 5'b0) bad++;
        end
        left_right_clk_falling_edge = 1'b0;
        check("reset_mid_shift_outputs", bad, 0);
        pops = 0; ones = 0;
        for (int c = 0; c < 64; c++) begin
            bit_clk_falling_edge       = (c % 2 == 0);
            left_right_clk_rising_edge = (c == 20);
            @(posedge clk);
            #1;
            if (left_fifo_read || right_fifo_read) pops++;
            if (serial_audio_out_data) ones++;
        end
        bit_clk_falling_edge = 1'b0;
        left_right_clk_rising_edge = 1'b0;
        check("post_reset_pops", pops, 0);
        check("post_reset_data", ones, 0);

        frame_checks("recover", vecs[0], 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
